ex_flag_unit: RTL and testbench
===============================

Name: ex_flag_unit

Overview:
- Condition-flag stage directly downstream of the execute-stage ALU.
- Captures Z/V/N from each committing EX instruction under per-opcode update rules.
- Resolves B/BR branch conditions for the fetch/decode path and latches HLT.
- Owns the only architectural flag register in the 16-bit core; the hazard unit controls it through stall/flush.

Parameters:
- DATA_W, 16, width of the ALU result bus.
- FWD_FLAGS, 1, 1 = branch evaluation sees flags produced by the instruction committing this cycle (bypass); 0 = registered flags only.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_opcode  input  4  opcode of the EX instruction (ISA opcode map).
- ex_result  input  DATA_W  ALU result.
- ex_ovfl  input  1  ALU overflow/Error output.
- stall  input  1  hazard unit holds EX; nothing commits.
- flush  input  1  EX instruction squashed; nothing commits.
- br_valid  input  1  decode presents a B (1100) or BR (1101).
- br_cond  input  3  branch condition code ccc.
- flag_z  output  1  registered zero flag.
- flag_v  output  1  registered overflow flag.
- flag_n  output  1  registered sign flag.
- br_taken  output  1  combinational branch decision.
- halted  output  1  sticky halt indicator.

Behaviour:
- Reset (async, rst_n low): flag_z = 0, flag_v = 0, flag_n = 0, halted = 0. Outputs take reset values immediately, with no clock edge needed. br_taken follows from the reset flags.
- commit = ex_valid & ~stall & ~flush & ~halted.
- Computed flags: z_new = (ex_result == 0); n_new = ex_result[DATA_W-1]; v_new = ex_ovfl.
- Flag update rules on a rising edge with commit = 1:
  - ADD 0000, SUB 0001: write Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; V and N hold.
  - RED 0011, PADDSB 0111, and opcodes 1000-1111: no flag write.
- commit = 0: all flags hold.
- Latency: a flag written in cycle t is visible on flag_* from cycle t+1.
- Effective flags eff_*:
  - FWD_FLAGS = 1 and commit = 1 with a flag-writing opcode: eff_* = the next-state value of each flag, bypassed the same cycle. Only the flags that opcode writes are bypassed; the others come from the register.
  - Otherwise: eff_* = registered flags.
- br_taken = br_valid & cond(br_cond, eff_*); br_taken = 0 whenever br_valid = 0. Condition codes:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always taken.
- Halt: on a rising edge with commit = 1 and ex_opcode = 1111, halted <= 1. It is sticky until reset.
  - After halted = 1, commit is forced to 0, so the flags freeze.
  - br_taken still evaluates on the frozen flags.
- Simultaneous stall and flush: no commit; the flags hold.
- HLT under flush or stall: halted does not set.
- Reset mid-operation: all state clears asynchronously; a commit in progress on that edge is lost.
- No internal X-propagation: br_cond values are fully decoded.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_ADD ... OP_HLT, 4-bit);
  - condition-code localparams (CC_NE ... CC_UNC, 3-bit);
  - a flag index/struct {z, v, n}.
- The same package is reused by decode and the ALU wrapper.
- One sub-module, br_cond_eval: pure combinational, inputs ccc plus z/v/n, output taken. Decode reuses it for static prediction checks.

Test Plan:
- Reset check: rst_n low asynchronously mid-cycle -> flags 0, halted 0 at once; br_valid = 1, br_cond = 001 -> br_taken = 0; br_cond = 000 -> br_taken = 1.
- ADD commit: ADD, result 0x0000, ovfl = 1, commit -> next cycle Z = 1, V = 1, N = 0. Then XOR, result 0x8000 -> Z = 0, V = 1 and N = 0 held.
- No-write opcodes: PADDSB with result 0x0000 and RED with result 0x0000 -> flags unchanged. SUB, result 0xFFFE, ovfl = 0 -> Z = 0, V = 0, N = 1; br_cond 011 taken, 010 not taken, 101 taken.
- Forwarding: same cycle as SUB result 0 commits, br_valid = 1, br_cond = 001 -> br_taken = 1 with FWD_FLAGS = 1 and 0 with FWD_FLAGS = 0 (prior Z = 0).
- Stall/flush: ADD result 0 with stall = 1, then with flush = 1, then with both -> Z unchanged each cycle. Release -> Z = 1 next cycle.
- Halt: HLT with flush = 1 -> halted stays 0. HLT committed -> halted = 1 next cycle. Following ADD result 0 -> Z holds, halted stays 1 until rst_n pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit core.
// Used by decode, the ALU wrapper and the EX flag stage.
//   - 4-bit ISA opcode map (OP_*)
//   - 3-bit branch condition codes (CC_*)
//   - flags_t: the architectural {z, v, n} flag triple
//   - flag_write_mask(): which flags each opcode writes when it commits
package cpu_pkg;

  // ISA opcode map
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // Branch condition codes (ccc field of B / BR)
  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  // Bit positions of each flag inside a packed flags_t
  localparam int unsigned FLAG_IDX_N = 0;
  localparam int unsigned FLAG_IDX_V = 1;
  localparam int unsigned FLAG_IDX_Z = 2;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Per-opcode flag write enables. Arithmetic writes all three flags, the
  // logical/shift group writes Z only, everything else leaves flags alone.
  function automatic flags_t flag_write_mask(input logic [3:0] opcode);
    flags_t mask;
    mask = '0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        mask.z = 1'b1;
        mask.v = 1'b1;
        mask.n = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        mask.z = 1'b1;
      end
      default: begin
        mask = '0;
      end
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: pure combinational branch-condition evaluator.
// Shared by the EX flag stage and decode (static prediction checks).
// Ports:
//   ccc   in  3  branch condition code
//   z     in  1  zero flag
//   v     in  1  overflow flag
//   n     in  1  sign flag
//   taken out 1  condition holds for the given flags
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      // Z | (~Z & ~N) reduces to Z | ~N
      CC_GE:   taken = z | ~n;
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_unit.sv
// ex_flag_unit: condition-flag stage downstream of the EX-stage ALU.
// Holds the core's architectural Z/V/N register, updates it from each
// committing instruction by opcode, resolves B/BR conditions and latches HLT.
// Ports:
//   clk        in  1       core clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   ex_valid   in  1       EX holds a real instruction
//   ex_opcode  in  4       EX opcode
//   ex_result  in  DATA_W  ALU result
//   ex_ovfl    in  1       ALU overflow
//   stall      in  1       hazard unit holds EX (no commit)
//   flush      in  1       EX instruction squashed (no commit)
//   br_valid   in  1       decode presents B / BR
//   br_cond    in  3       branch condition code
//   flag_z/v/n out 1       registered flags
//   br_taken   out 1       combinational branch decision
//   halted     out 1       sticky halt indicator
module ex_flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FWD_FLAGS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              br_taken,
  output logic              halted
);

  logic   commit;
  flags_t flags_new;
  flags_t wr_mask;
  flags_t flags_d, flags_q;
  flags_t eff;
  logic   halted_d, halted_q;
  logic   cond_taken;

  always_comb begin
    // Once halted nothing commits, which freezes the flags.
    commit = ex_valid & ~stall & ~flush & ~halted_q;

    flags_new.z = (ex_result == '0);
    flags_new.v = ex_ovfl;
    flags_new.n = ex_result[DATA_W-1];

    wr_mask = commit ? flag_write_mask(ex_opcode) : '0;

    flags_d.z = wr_mask.z ? flags_new.z : flags_q.z;
    flags_d.v = wr_mask.v ? flags_new.v : flags_q.v;
    flags_d.n = wr_mask.n ? flags_new.n : flags_q.n;

    halted_d = halted_q | (commit & (ex_opcode == OP_HLT));

    // flags_d already equals flags_q for any flag not written this cycle, so
    // bypassing flags_d forwards exactly the flags the committing opcode writes.
    eff = (FWD_FLAGS != 0) ? flags_d : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  br_cond_eval u_br_cond_eval (
    .ccc   (br_cond),
    .z     (eff.z),
    .v     (eff.v),
    .n     (eff.n),
    .taken (cond_taken)
  );

  assign br_taken = br_valid & cond_taken;
  assign flag_z   = flags_q.z;
  assign flag_v   = flags_q.v;
  assign flag_n   = flags_q.n;
  assign halted   = halted_q;

endmodule

// File: tb/tb_ex_flag_unit.sv
// Self-checking bench for ex_flag_unit. Two instances share stimulus: one
// with flag forwarding, one with registered-only flags.
module tb_ex_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = 4'd0;
  logic [15:0] ex_result = 16'd0;
  logic        ex_ovfl = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'd0;

  logic fz_f, fv_f, fn_f, bt_f, h_f;
  logic fz_r, fv_r, fn_r, bt_r, h_r;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  ex_flag_unit #(.DATA_W(16), .FWD_FLAGS(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_cond(br_cond), .flag_z(fz_f), .flag_v(fv_f),
    .flag_n(fn_f), .br_taken(bt_f), .halted(h_f)
  );

  ex_flag_unit #(.DATA_W(16), .FWD_FLAGS(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_cond(br_cond), .flag_z(fz_r), .flag_v(fv_r),
    .flag_n(fn_r), .br_taken(bt_r), .halted(h_r)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_z, m_v, m_n, m_h;

  function automatic bit model_commit();
    return ex_valid && !stall && !flush && !m_h;
  endfunction

  // Flags as they will be after this cycle's edge: {z, v, n}
  function automatic bit [2:0] model_next();
    bit z, v, n;
    z = m_z; v = m_v; n = m_n;
    if (model_commit()) begin
      if (ex_opcode == 4'd0 || ex_opcode == 4'd1) begin
        z = (ex_result == 16'd0);
        v = ex_ovfl;
        n = (ex_result >= 16'h8000);
      end else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                   ex_opcode == 4'd5 || ex_opcode == 4'd6) begin
        z = (ex_result == 16'd0);
      end
    end
    return {z, v, n};
  endfunction

  function automatic bit cond_ok(input bit [2:0] c, input bit z, input bit v, input bit n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_z <= 1'b0; m_v <= 1'b0; m_n <= 1'b0; m_h <= 1'b0;
    end else begin
      bit [2:0] nx;
      nx = model_next();
      m_z <= nx[2]; m_v <= nx[1]; m_n <= nx[0];
      if (model_commit() && ex_opcode == 4'd15) m_h <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit [2:0] nx;
      nx = model_next();
      check("cyc_z_fwd", fz_f, m_z);
      check("cyc_v_fwd", fv_f, m_v);
      check("cyc_n_fwd", fn_f, m_n);
      check("cyc_h_fwd", h_f, m_h);
      check("cyc_z_reg", fz_r, m_z);
      check("cyc_v_reg", fv_r, m_v);
      check("cyc_n_reg", fn_r, m_n);
      check("cyc_h_reg", h_r, m_h);
      check("cyc_br_fwd", bt_f, br_valid && cond_ok(br_cond, nx[2], nx[1], nx[0]));
      check("cyc_br_reg", bt_r, br_valid && cond_ok(br_cond, m_z, m_v, m_n));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [3:0] op, input logic [15:0] res, input logic ov,
                      input logic st, input logic fl);
    ex_valid = 1'b1; ex_opcode = op; ex_result = res; ex_ovfl = ov;
    stall = st; flush = fl;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic z, input logic v, input logic n);
    check({name, "_z"}, fz_f, z);
    check({name, "_v"}, fv_f, v);
    check({name, "_n"}, fn_f, n);
    check({name, "_zr"}, fz_r, z);
  endtask

  task automatic chk_br(input string name, input logic [2:0] c, input logic exp);
    br_valid = 1'b1; br_cond = c;
    #1;
    check({name, "_fwd"}, bt_f, exp);
    check({name, "_reg"}, bt_r, exp);
    br_valid = 1'b0;
  endtask

  initial begin
    // Asynchronous reset, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_halt", h_f, 1'b0);
    chk_br("rst_br_eq", 3'b001, 1'b0);
    chk_br("rst_br_ne", 3'b000, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    step(4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_flags("add0", 1'b1, 1'b1, 1'b0);
    step(4'b0010, 16'h8000, 1'b0, 1'b0, 1'b0);
    chk_flags("xor8000", 1'b0, 1'b1, 1'b0);

    step(4'b0111, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_flags("paddsb", 1'b0, 1'b1, 1'b0);
    step(4'b0011, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_flags("red", 1'b0, 1'b1, 1'b0);
    step(4'b0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    chk_flags("sub_neg", 1'b0, 1'b0, 1'b1);
    chk_br("br_lt", 3'b011, 1'b1);
    chk_br("br_gt", 3'b010, 1'b0);
    chk_br("br_le", 3'b101, 1'b1);

    // Forwarding: SUB result 0 commits while EQ branch is evaluated
    ex_valid = 1'b1; ex_opcode = 4'b0001; ex_result = 16'h0000; ex_ovfl = 1'b0;
    br_valid = 1'b1; br_cond = 3'b001;
    #1;
    check("fwd_eq_fwd", bt_f, 1'b1);
    check("fwd_eq_reg", bt_r, 1'b0);
    @(posedge clk);
    #1;
    ex_valid = 1'b0; br_valid = 1'b0;
    chk_flags("sub0", 1'b1, 1'b0, 1'b0);

    // Stall / flush
    step(4'b0010, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk_flags("xor1", 1'b0, 1'b0, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("stall_z", fz_f, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("flush_z", fz_f, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("both_z", fz_f, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("release_z", fz_f, 1'b1);

    // Every non-halting opcode, with a branch probe during commit
    for (int op = 0; op < 15; op++) begin
      step(4'b0000, 16'h1234, 1'b0, 1'b0, 1'b0);
      br_valid = 1'b1;
      br_cond = 3'(op);
      step(4'(op), 16'h0000, 1'b1, 1'b0, 1'b0);
      br_valid = 1'b0;
    end
    // All condition codes on a couple of flag states
    step(4'b0001, 16'h8001, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      br_valid = 1'b1; br_cond = 3'(c);
      @(negedge clk);
    end
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      br_valid = 1'b1; br_cond = 3'(c);
      @(negedge clk);
    end
    br_valid = 1'b0;
    #1;

    // Halt
    step(4'b0000, 16'h0005, 1'b0, 1'b0, 1'b0);
    chk_flags("add5", 1'b0, 1'b0, 1'b0);
    step(4'b1111, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("hlt_flush", h_f, 1'b0);
    step(4'b1111, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("hlt_stall", h_f, 1'b0);
    step(4'b1111, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("hlt_fwd", h_f, 1'b1);
    check("hlt_reg", h_r, 1'b1);
    ex_valid = 1'b1; ex_opcode = 4'b0000; ex_result = 16'h0000;
    chk_br("halt_eq", 3'b001, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("halt_z_hold", fz_f, 1'b0);
    check("halt_sticky", h_f, 1'b1);
    chk_br("halt_ne", 3'b000, 1'b1);
    repeat (2) @(posedge clk);

    // Reset pulse mid-cycle clears everything immediately
    #3 rst_n = 1'b0;
    #1;
    chk_flags("rst2", 1'b0, 1'b0, 1'b0);
    check("rst2_halt", h_f, 1'b0);
    check("rst2_halt_reg", h_r, 1'b0);
    chk_br("rst2_eq", 3'b001, 1'b0);
    chk_br("rst2_ne", 3'b000, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_flags("post_rst_add", 1'b1, 1'b0, 1'b0);
    check("post_rst_halt", h_f, 1'b0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
